// File: rtl/image_pkg.sv
// Shared definitions for the image frame scheduler: opcodes, FSM states, default sizes.
// Opcode legality is centralised here so the top and any future users agree on it.
package image_pkg;

    localparam int DIM_W_DEF      = 11;

    localparam int OPC_BRIGHTNESS = 0;
    localparam int OPC_GRAYSCALE  = 1;
    localparam int OPC_ROTATE     = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_SCAN  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Opcode 3 (and anything wider) is reserved; rotate depends on the build.
    function automatic logic op_legal(input int unsigned op, input logic rot_en);
        return (op == OPC_BRIGHTNESS) || (op == OPC_GRAYSCALE) ||
               ((op == OPC_ROTATE) && rot_en);
    endfunction

endpackage

// File: rtl/image_raster_cnt.sv
// Two-dimensional wrap counter: the inner index steps on every advance, the outer one on inner wrap.
// Limits are given as maximum index values (dimension - 1); the whole counter wraps to (0,0) after the last point.
module image_raster_cnt #(
    parameter int W = 11
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clear_i,
    input  logic         advance_i,
    input  logic [W-1:0] inner_max_i,
    input  logic [W-1:0] outer_max_i,
    output logic [W-1:0] inner_o,
    output logic [W-1:0] outer_o,
    output logic         last_inner_o,
    output logic         last_outer_o
);

    logic [W-1:0] inner_q, inner_d;
    logic [W-1:0] outer_q, outer_d;

    assign last_inner_o = (inner_q == inner_max_i);
    assign last_outer_o = (outer_q == outer_max_i);
    assign inner_o      = inner_q;
    assign outer_o      = outer_q;

    always_comb begin
        inner_d = inner_q;
        outer_d = outer_q;
        if (clear_i) begin
            inner_d = '0;
            outer_d = '0;
        end else if (advance_i) begin
            if (last_inner_o) begin
                inner_d = '0;
                outer_d = last_outer_o ? '0 : outer_q + W'(1);
            end else begin
                inner_d = inner_q + W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            inner_q <= '0;
            outer_q <= '0;
        end else begin
            inner_q <= inner_d;
            outer_q <= outer_d;
        end
    end

endmodule

// File: rtl/image_frame_sched.sv
// Frame scheduler: walks every pixel coordinate of a requested frame once, row-major or (build option
// IMAGE_FRAME_SCHED_ROTATE_EN) column-major for ROTATE, with valid/ready stalls and one-cycle done/err pulses.
module image_frame_sched
    import image_pkg::*;
#(
    parameter int DIM_W = DIM_W_DEF,
    parameter int OP_W  = 2
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             start,
    input  logic [OP_W-1:0]  opcode_in,
    input  logic [DIM_W-1:0] width,
    input  logic [DIM_W-1:0] height,
    input  logic             pix_ready,
    output logic             pix_valid,
    output logic [DIM_W-1:0] row,
    output logic [DIM_W-1:0] col,
    output logic [OP_W-1:0]  opcode_out,
    output logic             sof,
    output logic             eol,
    output logic             eof,
    output logic             busy,
    output logic             done,
    output logic             err
);

`ifdef IMAGE_FRAME_SCHED_ROTATE_EN
    localparam logic ROT_EN = 1'b1;
`else
    localparam logic ROT_EN = 1'b0;
`endif

    state_t           state_q, state_d;
    logic [OP_W-1:0]  opcode_q, opcode_d;
    logic [DIM_W-1:0] wmax_q, wmax_d;
    logic [DIM_W-1:0] hmax_q, hmax_d;
    logic             err_q, err_d;

    logic             req_legal;
    logic             cnt_clear;
    logic             cnt_advance;
    logic [DIM_W-1:0] inner_max, outer_max;
    logic [DIM_W-1:0] inner, outer;
    logic             last_inner, last_outer;

    assign req_legal = (width != '0) && (height != '0) &&
                       op_legal(int'(opcode_in), ROT_EN);

`ifdef IMAGE_FRAME_SCHED_ROTATE_EN
    logic colmaj_q, colmaj_d;

    assign colmaj_d  = (state_q == ST_IDLE) && start && req_legal ?
                       (opcode_in == OP_W'(OPC_ROTATE)) : colmaj_q;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            colmaj_q <= 1'b0;
        end else begin
            colmaj_q <= colmaj_d;
        end
    end

    // Column-major swaps which axis is the fast-moving inner index.
    assign inner_max = colmaj_q ? hmax_q : wmax_q;
    assign outer_max = colmaj_q ? wmax_q : hmax_q;
    assign row       = colmaj_q ? inner  : outer;
    assign col       = colmaj_q ? outer  : inner;
`else
    assign inner_max = wmax_q;
    assign outer_max = hmax_q;
    assign row       = outer;
    assign col       = inner;
`endif

    image_raster_cnt #(
        .W (DIM_W)
    ) u_raster (
        .clk_i        (CLK),
        .rst_i        (RESET),
        .clear_i      (cnt_clear),
        .advance_i    (cnt_advance),
        .inner_max_i  (inner_max),
        .outer_max_i  (outer_max),
        .inner_o      (inner),
        .outer_o      (outer),
        .last_inner_o (last_inner),
        .last_outer_o (last_outer)
    );

    always_comb begin
        state_d     = state_q;
        opcode_d    = opcode_q;
        wmax_d      = wmax_q;
        hmax_d      = hmax_q;
        err_d       = 1'b0;
        cnt_clear   = 1'b0;
        cnt_advance = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (req_legal) begin
                        state_d  = ST_SETUP;
                        opcode_d = opcode_in;
                        wmax_d   = width - DIM_W'(1);
                        hmax_d   = height - DIM_W'(1);
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_SETUP: begin
                cnt_clear = 1'b1;
                state_d   = ST_SCAN;
            end
            ST_SCAN: begin
                if (pix_ready) begin
                    cnt_advance = 1'b1;
                    if (last_inner && last_outer) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= ST_IDLE;
            opcode_q <= '0;
            wmax_q   <= '0;
            hmax_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            wmax_q   <= wmax_d;
            hmax_q   <= hmax_d;
            err_q    <= err_d;
        end
    end

    // Markers derive from the held counter, so they hold with row/col during stalls.
    assign pix_valid  = (state_q == ST_SCAN);
    assign sof        = pix_valid && (row == '0) && (col == '0);
    assign eol        = pix_valid && last_inner;
    assign eof        = pix_valid && last_inner && last_outer;
    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_DONE);
    assign err        = err_q;
    assign opcode_out = opcode_q;

endmodule
